// File: rtl/data_bus_arbiter.sv
// rtl/data_bus_arbiter.sv - round-robin burst arbiter sharing one data/valid bus among NUM_REQ requesters
module data_bus_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic [15:0]                   beat_total
);

    localparam int OWN_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state;
    logic [OWN_W-1:0]   last_owner;
    logic [CNT_W-1:0]   beat_cnt;

    logic               xfer;
    logic               last_beat;
    logic               burst_end;
    logic [OWN_W-1:0]   arb_base;
    logic               found;
    logic [OWN_W-1:0]   winner;
    logic [NUM_REQ-1:0] winner_onehot;

    // A beat moves only while a burst is open and the owner is presenting it.
    assign xfer      = (state == BURST) && req[owner] && out_ready;
    assign last_beat = (beat_cnt == CNT_W'(MAX_BURST - 1));

    // The owner withdrawing its request closes the burst even during a stall;
    // the stalled beat is simply never counted.
    assign burst_end = (state == BURST) && (!req[owner] || (xfer && last_beat));

    // At burst end the current owner becomes the new search origin, so it can
    // only win again when nobody else is asking.
    assign arb_base = (state == BURST) ? owner : last_owner;

    // Round-robin search starting one past arb_base, first set request wins.
    always_comb begin
        logic [OWN_W-1:0] idx;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = OWN_W'((int'(arb_base) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;

    // Bus mux: the owner's valid and data pass straight through; idle bus is quiet.
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        if (state == BURST) begin
            out_valid = req[owner];
            out_data  = req_data[owner*DATA_W +: DATA_W];
        end
    end

    // Arbitration FSM with registered grant, owner and beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= '0;
            owner      <= '0;
            beat_cnt   <= '0;
            beat_total <= '0;
            last_owner <= OWN_W'(NUM_REQ - 1);
        end else begin
            if (xfer) begin
                beat_total <= beat_total + 16'd1;
            end
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (found) begin
                        state <= BURST;
                        owner <= winner;
                        gnt   <= winner_onehot;
                    end else begin
                        owner <= '0;
                        gnt   <= '0;
                    end
                end
                BURST: begin
                    if (burst_end) begin
                        last_owner <= owner;
                        beat_cnt   <= '0;
                        if (found) begin
                            owner <= winner;
                            gnt   <= winner_onehot;
                        end else begin
                            state <= IDLE;
                            owner <= '0;
                            gnt   <= '0;
                        end
                    end else if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= '0;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb/tb_data_bus_arbiter.sv - directed scoreboard bench for data_bus_arbiter
module tb_data_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  owner;
    logic [15:0] beat_total;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;
    logic [15:0] sb[$];
    logic [15:0] mon_exp;

    data_bus_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .owner      (owner),
        .beat_total (beat_total)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        req_data[i*8 +: 8] = v;
    endtask

    task automatic push(input int o, input logic [7:0] v);
        sb.push_back({8'(o), v});
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = 4'b0000;
        out_ready = 1'b1;
        step;
        step;
        rst = 1'b0;
    endtask

    // Scoreboard monitor: every transfer must match the oldest expected beat.
    always @(negedge clk) begin
        if (mon_on) begin
            total++;
            assert ($onehot0(gnt) === 1'b1) else begin
                bad++;
                $error("FAIL gnt_onehot got=%0b exp=onehot0", gnt);
            end
            if (out_valid === 1'b1 && out_ready && !rst) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $error("FAIL sb_underflow got=%0h:%0h exp=none", owner, out_data);
                end else begin
                    mon_exp = sb.pop_front();
                    assert ({6'd0, owner, out_data} === mon_exp) else begin
                        bad++;
                        $error("FAIL beat got=%0h:%0h exp=%0h:%0h", owner, out_data, mon_exp[15:8], mon_exp[7:0]);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        req_data = '0;
        out_ready = 1'b1;

        // Reset state
        do_reset;
        mon_on = 1'b1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_owner", owner, 2'd0);
        chk("rst_total", beat_total, 16'd0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 8'd0);

        // Single requester, 20 beats, back-to-back bursts of 8
        req = 4'b0010;
        set_data(1, 8'd1);
        step;
        chk("single_gnt", gnt, 4'b0010);
        chk("single_owner", owner, 2'd1);
        for (int k = 1; k <= 20; k++) begin
            set_data(1, 8'(k));
            push(1, 8'(k));
            chk("single_valid", out_valid, 1'b1);
            chk("single_gnt_hold", gnt, 4'b0010);
            step;
        end
        chk("single_total", beat_total, 16'd20);
        req = 4'b0000;
        step;
        chk("single_idle_gnt", gnt, 4'b0000);
        chk("idle_valid", out_valid, 1'b0);
        chk("idle_data", out_data, 8'd0);

        // All four requesting: order 0,1,2,3,0 with 8 beats each
        do_reset;
        req = 4'b1111;
        req_data = 32'hEEEEEEEE;
        step;
        for (int b = 0; b < 40; b++) begin
            int o;
            o = (b / 8) % 4;
            req_data = 32'hEEEEEEEE;
            set_data(o, 8'(o * 16 + b % 8));
            push(o, 8'(o * 16 + b % 8));
            chk("rr_gnt", gnt, 32'(1) << o);
            chk("rr_owner", owner, 32'(o));
            step;
        end
        chk("rr_next_gnt", gnt, 4'b0010);
        chk("rr_total", beat_total, 16'd40);
        req = 4'b0000;
        step;
        chk("rr_idle_gnt", gnt, 4'b0000);

        // Owner 2 drops after 3 beats while requester 3 waits
        do_reset;
        req = 4'b0100;
        set_data(2, 8'h20);
        step;
        chk("drop_gnt", gnt, 4'b0100);
        chk("drop_owner", owner, 2'd2);
        req = 4'b1100;
        set_data(3, 8'h77);
        for (int b = 0; b < 3; b++) begin
            set_data(2, 8'(8'h20 + b));
            push(2, 8'(8'h20 + b));
            step;
            chk("drop_ignore_3", gnt, 4'b0100);
        end
        req = 4'b1000;
        step;
        chk("drop_next_gnt", gnt, 4'b1000);
        chk("drop_next_owner", owner, 2'd3);
        chk("drop_total", beat_total, 16'd3);
        req = 4'b0000;
        step;
        chk("drop_idle_gnt", gnt, 4'b0000);

        // Backpressure: 5 stalled cycles mid-burst, burst still 8 transfers
        do_reset;
        req = 4'b0011;
        set_data(0, 8'h50);
        set_data(1, 8'h99);
        step;
        chk("bp_gnt", gnt, 4'b0001);
        for (int b = 0; b < 8; b++) begin
            set_data(0, 8'(8'h50 + b));
            push(0, 8'(8'h50 + b));
            if (b == 3) begin
                out_ready = 1'b0;
                repeat (5) begin
                    step;
                    chk("bp_stall_gnt", gnt, 4'b0001);
                    chk("bp_stall_data", out_data, 8'h53);
                    chk("bp_stall_valid", out_valid, 1'b1);
                end
                out_ready = 1'b1;
            end
            chk("bp_gnt_hold", gnt, 4'b0001);
            step;
        end
        chk("bp_next_gnt", gnt, 4'b0010);
        chk("bp_total", beat_total, 16'd8);
        req = 4'b0000;
        step;
        chk("bp_idle_gnt", gnt, 4'b0000);

        // Reset mid-burst after 4 beats of owner 1
        do_reset;
        req = 4'b0010;
        set_data(1, 8'h40);
        step;
        chk("mrst_gnt", gnt, 4'b0010);
        for (int b = 0; b < 4; b++) begin
            set_data(1, 8'(8'h40 + b));
            push(1, 8'(8'h40 + b));
            step;
        end
        set_data(1, 8'h44);
        rst = 1'b1;
        step;
        chk("mrst_gnt0", gnt, 4'b0000);
        chk("mrst_total0", beat_total, 16'd0);
        chk("mrst_valid0", out_valid, 1'b0);
        chk("mrst_owner0", owner, 2'd0);
        rst = 1'b0;
        req = 4'b1111;
        step;
        chk("mrst_first_gnt", gnt, 4'b0001);
        req = 4'b0000;
        step;
        chk("mrst_idle_gnt", gnt, 4'b0000);

        // beat_total wrap after 65537 transfers
        do_reset;
        req = 4'b0001;
        set_data(0, 8'h00);
        step;
        for (int k = 0; k <= 65536; k++) begin
            set_data(0, 8'(k));
            push(0, 8'(k));
            step;
            if (k == 65534) chk("wrap_ffff", beat_total, 16'hFFFF);
        end
        chk("wrap_total", beat_total, 16'd1);
        req = 4'b0000;
        step;
        chk("wrap_idle_gnt", gnt, 4'b0000);

        chk("sb_empty", sb.size(), 32'd0);
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
